// File: rtl/bitonic_32_loader.sv
// Packs a LANES-wide valid/ready element stream into DATALENGTH-wide frames
// for the bitonic sorter, padding short frames and strobing each finished vector.
module bitonic_32_loader #(
  parameter int unsigned          DATAWIDTH  = 8,
  parameter int unsigned          DATALENGTH = 32,
  parameter int unsigned          LANES      = 4,
  parameter logic [DATAWIDTH-1:0] PAD_VALUE  = '0,
  parameter int unsigned          IDW        = 4,
  localparam int unsigned         NW         = $clog2(LANES + 1),
  localparam int unsigned         CW         = $clog2(DATALENGTH + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [LANES-1:0][DATAWIDTH-1:0]      in_data_i,
  input  logic [NW-1:0]                        in_num_i,
  input  logic                                 in_last_i,
  output logic                                 vec_valid_o,
  output logic [DATALENGTH-1:0][DATAWIDTH-1:0] vec_o,
  output logic [CW-1:0]                        vec_len_o,
  output logic [IDW-1:0]                       frame_id_o
);

  typedef enum logic {FILL, EMIT} state_t;

  state_t                               state_q, state_d;
  logic                                 ready_q;
  logic [DATALENGTH-1:0][DATAWIDTH-1:0] fill_q, fill_d, vec_d;
  logic [CW-1:0]                        cnt_q, take, cnt_sum;
  logic                                 accept, done;

  // Non-last beats are always full; a last beat contributes at most LANES.
  function automatic logic [CW-1:0] lanes_taken(input logic last, input logic [NW-1:0] num);
    if (!last) return CW'(LANES);
    if (num > NW'(LANES)) return CW'(LANES);
    return CW'(num);
  endfunction

  assign in_ready_o = ready_q;

  always_comb begin
    accept  = in_valid_i && ready_q;
    take    = lanes_taken(in_last_i, in_num_i);
    cnt_sum = cnt_q + take;
    done    = accept && ((cnt_sum == CW'(DATALENGTH)) || (in_last_i && (cnt_sum != '0)));
    fill_d  = fill_q;
    vec_d   = fill_q;
    // cnt_q is always a multiple of LANES when a beat lands, so slot k takes lane k%LANES.
    for (int k = 0; k < int'(DATALENGTH); k++) begin
      if (accept && (k >= int'(cnt_q)) && (k < int'(cnt_sum)))
        fill_d[k] = in_data_i[k % int'(LANES)];
      vec_d[k] = (k < int'(cnt_sum)) ? fill_d[k] : PAD_VALUE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (done) state_d = EMIT;
      EMIT:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Ready is registered from the next state so it is low during reset and the strobe cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= FILL;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == FILL);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fill_q      <= {DATALENGTH{PAD_VALUE}};
      cnt_q       <= '0;
      vec_valid_o <= 1'b0;
      vec_o       <= {DATALENGTH{PAD_VALUE}};
      vec_len_o   <= '0;
      frame_id_o  <= '0;
    end else begin
      vec_valid_o <= done;
      if (state_q == EMIT) begin
        fill_q <= {DATALENGTH{PAD_VALUE}};
        cnt_q  <= '0;
      end else if (accept) begin
        fill_q <= fill_d;
        cnt_q  <= cnt_sum;
      end
      if (done) begin
        vec_o      <= vec_d;
        vec_len_o  <= cnt_sum;
        frame_id_o <= frame_id_o + IDW'(1);
      end
    end
  end

endmodule
